polygon_loader: RTL and testbench



---
 rtl/polygon_loader.sv | 189 ++++++++++++++++++
 tb/tb_polygon_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polygon_loader.sv
// Vertex-list loader: fetches a polygon from vertex BRAM into a shadow bank and commits it atomically on swap.
// Optional bounding-box tracking is built when POLYGON_LOADER_BBOX_EN is defined.
module polygon_loader #(
   parameter int unsigned WORLD_BITS       = 32,
   parameter int unsigned MAX_NUM_VERTICES = 32,
   parameter int unsigned ADDR_BITS        = 10,
   parameter int unsigned MEM_LATENCY      = 2
) (
   input  logic                                       clk_in,
   input  logic                                       rst_in,
   input  logic                                       start_in,
   input  logic [ADDR_BITS-1:0]                       base_addr_in,
   input  logic [$clog2(MAX_NUM_VERTICES+1)-1:0]      count_in,
   input  logic                                       swap_in,
   output logic [ADDR_BITS-1:0]                       mem_addr_out,
   input  logic [2*WORLD_BITS-1:0]                    mem_data_in,
   output logic signed [WORLD_BITS-1:0]               poly_xs_out [MAX_NUM_VERTICES],
   output logic signed [WORLD_BITS-1:0]               poly_ys_out [MAX_NUM_VERTICES],
   output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]      num_points_out,
   output logic                                       busy_out,
   output logic                                       ready_out,
   output logic                                       error_out,
   output logic signed [WORLD_BITS-1:0]               bbox_min_x_out,
   output logic signed [WORLD_BITS-1:0]               bbox_max_x_out,
   output logic signed [WORLD_BITS-1:0]               bbox_min_y_out,
   output logic signed [WORLD_BITS-1:0]               bbox_max_y_out
);
   localparam int unsigned CW = $clog2(MAX_NUM_VERTICES + 1);
   localparam int unsigned IW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
   localparam int unsigned LAST = MEM_LATENCY - 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]             state, next_state;
   logic [CW-1:0]          idx, count_q;
   logic [MEM_LATENCY-1:0] pipe_vld;
   logic [IW-1:0]          pipe_idx [MEM_LATENCY];
   logic                   accept, too_big, commit, issue;

   logic signed [WORLD_BITS-1:0] sh_xs [MAX_NUM_VERTICES];
   logic signed [WORLD_BITS-1:0] sh_ys [MAX_NUM_VERTICES];
   logic signed [WORLD_BITS-1:0] word_x, word_y;

   assign word_x = mem_data_in[2*WORLD_BITS-1:WORLD_BITS];
   assign word_y = mem_data_in[WORLD_BITS-1:0];

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and control decode; count 0 passes through an empty DRAIN so ready lands one edge later
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      too_big    = 1'b0;
      issue      = 1'b0;
      commit     = swap_in && ready_out;
      case (state)
         IDLE, DONE: begin
            if (commit) next_state = IDLE;
            if (start_in) begin
               if (count_in > CW'(MAX_NUM_VERTICES)) begin
                  too_big = 1'b1;
               end else begin
                  accept     = 1'b1;
                  next_state = (count_in == '0) ? DRAIN : FETCH;
               end
            end
         end
         FETCH: begin
            issue = 1'b1;
            if (idx == count_q - CW'(1)) next_state = DRAIN;
         end
         DRAIN: begin
            if (pipe_vld == '0) next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Address issue, return pipeline, shadow bank, commit and status flags
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         idx            <= '0;
         count_q        <= '0;
         mem_addr_out   <= '0;
         pipe_vld       <= '0;
         num_points_out <= '0;
         busy_out       <= 1'b0;
         ready_out      <= 1'b0;
         error_out      <= 1'b0;
         for (int i = 0; i < int'(MEM_LATENCY); i++) pipe_idx[i] <= '0;
         for (int i = 0; i < int'(MAX_NUM_VERTICES); i++) begin
            sh_xs[i]       <= '0;
            sh_ys[i]       <= '0;
            poly_xs_out[i] <= '0;
            poly_ys_out[i] <= '0;
         end
      end else begin
         busy_out  <= (next_state == FETCH) ||
                      ((next_state == DRAIN) && ((state == FETCH) || (state == DRAIN)));
         ready_out <= (next_state == DONE);
         error_out <= too_big;

         if (accept) begin
            idx          <= '0;
            count_q      <= count_in;
            mem_addr_out <= base_addr_in;
         end else if (issue) begin
            idx          <= idx + CW'(1);
            mem_addr_out <= mem_addr_out + ADDR_BITS'(1);
         end

         pipe_vld[0] <= issue;
         pipe_idx[0] <= IW'(idx);
         for (int i = 1; i < int'(MEM_LATENCY); i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
         end

         if (pipe_vld[LAST]) begin
            sh_xs[pipe_idx[LAST]] <= word_x;
            sh_ys[pipe_idx[LAST]] <= word_y;
         end

         // Commit reads the pre-edge shadow, so a same-cycle restart cannot tear it
         if (commit) begin
            num_points_out <= count_q;
            for (int i = 0; i < int'(MAX_NUM_VERTICES); i++) begin
               poly_xs_out[i] <= sh_xs[i];
               poly_ys_out[i] <= sh_ys[i];
            end
         end
      end
   end

`ifdef POLYGON_LOADER_BBOX_EN
   logic signed [WORLD_BITS-1:0] sh_min_x, sh_max_x, sh_min_y, sh_max_y;
   logic                         first_word;

   // Shadow bounding box follows the words as they land; the first word seeds all four bounds
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         first_word     <= 1'b1;
         sh_min_x       <= '0;
         sh_max_x       <= '0;
         sh_min_y       <= '0;
         sh_max_y       <= '0;
         bbox_min_x_out <= '0;
         bbox_max_x_out <= '0;
         bbox_min_y_out <= '0;
         bbox_max_y_out <= '0;
      end else begin
         if (accept) begin
            first_word <= 1'b1;
            if (count_in == '0) begin
               sh_min_x <= '0;
               sh_max_x <= '0;
               sh_min_y <= '0;
               sh_max_y <= '0;
            end
         end else if (pipe_vld[LAST]) begin
            first_word <= 1'b0;
            if (first_word || (word_x < sh_min_x)) sh_min_x <= word_x;
            if (first_word || (word_x > sh_max_x)) sh_max_x <= word_x;
            if (first_word || (word_y < sh_min_y)) sh_min_y <= word_y;
            if (first_word || (word_y > sh_max_y)) sh_max_y <= word_y;
         end
         if (commit) begin
            bbox_min_x_out <= sh_min_x;
            bbox_max_x_out <= sh_max_x;
            bbox_min_y_out <= sh_min_y;
            bbox_max_y_out <= sh_max_y;
         end
      end
   end
`else
   assign bbox_min_x_out = '0;
   assign bbox_max_x_out = '0;
   assign bbox_min_y_out = '0;
   assign bbox_max_y_out = '0;
`endif

endmodule

// File: tb/tb_polygon_loader.sv
// Directed bench for polygon_loader with a 2-cycle BRAM model; bbox expectations follow POLYGON_LOADER_BBOX_EN.
module tb_polygon_loader;
   localparam int unsigned W    = 32;
   localparam int unsigned MAXV = 32;
   localparam int unsigned AB   = 10;
   localparam int unsigned CW   = 6;

   logic                clk_in = 1'b0;
   logic                rst_in, start_in, swap_in;
   logic [AB-1:0]       base_addr_in, mem_addr_out;
   logic [CW-1:0]       count_in, num_points_out;
   logic [2*W-1:0]      mem_data_in;
   logic signed [W-1:0] xs [MAXV];
   logic signed [W-1:0] ys [MAXV];
   logic                busy_out, ready_out, error_out;
   logic signed [W-1:0] bminx, bmaxx, bminy, bmaxy;

   logic [2*W-1:0]      mem [1024];
   logic [2*W-1:0]      rd1, rd2;
   int                  checks = 0;
   int                  passes = 0;

   polygon_loader #(.WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV), .ADDR_BITS(AB), .MEM_LATENCY(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .base_addr_in(base_addr_in),
      .count_in(count_in), .swap_in(swap_in), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
      .poly_xs_out(xs), .poly_ys_out(ys), .num_points_out(num_points_out), .busy_out(busy_out),
      .ready_out(ready_out), .error_out(error_out), .bbox_min_x_out(bminx), .bbox_max_x_out(bmaxx),
      .bbox_min_y_out(bminy), .bbox_max_y_out(bmaxy));

   always #5 clk_in = ~clk_in;

   // Two-cycle synchronous BRAM
   always @(posedge clk_in) begin
      rd1 <= mem[mem_addr_out];
      rd2 <= rd1;
   end
   assign mem_data_in = rd2;

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   function automatic logic [W-1:0] mx(input logic [AB-1:0] a);
      logic [2*W-1:0] w;
      w = mem[a];
      return w[2*W-1:W];
   endfunction

   function automatic logic [W-1:0] my(input logic [AB-1:0] a);
      logic [2*W-1:0] w;
      w = mem[a];
      return w[W-1:0];
   endfunction

   task automatic start(input logic [AB-1:0] base, input logic [CW-1:0] cnt);
      base_addr_in = base;
      count_in     = cnt;
      start_in     = 1'b1;
      tick();
      start_in     = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (ready_out !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (ready_out !== 1'b1) $display("FAIL %s wait_ready: ready=%b after %0d cycles, required 1", tag, ready_out, n);
      else passes++;
   endtask

   task automatic swap;
      swap_in = 1'b1;
      tick();
      swap_in = 1'b0;
   endtask

   task automatic test_reset;
      rst_in = 1'b1; start_in = 1'b0; swap_in = 1'b0; base_addr_in = '0; count_in = '0;
      tick(); tick();
      checks++; if (num_points_out !== 6'd0) $display("FAIL reset num_points: got %0d required 0", num_points_out); else passes++;
      checks++; if ({busy_out, ready_out, error_out} !== 3'b000) $display("FAIL reset flags: got %b required 000", {busy_out, ready_out, error_out}); else passes++;
      checks++; if (mem_addr_out !== 10'd0) $display("FAIL reset mem_addr: got %h required 000", mem_addr_out); else passes++;
      checks++; if (xs[0] !== 0 || ys[31] !== 0) $display("FAIL reset arrays: xs0=%0d ys31=%0d required 0", xs[0], ys[31]); else passes++;
      checks++; if ({bminx, bmaxx, bminy, bmaxy} !== '0) $display("FAIL reset bbox: got nonzero, required 0"); else passes++;
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_basic_load;
      start(10'h010, 6'd4);
      // now just after accept edge t; k counts edges since t
      for (int k = 0; k <= 7; k++) begin
         if (k < 4) begin
            checks++; if (mem_addr_out !== 10'(10'h010 + k)) $display("FAIL basic addr k=%0d: got %h required %h", k, mem_addr_out, 10'(10'h010 + k)); else passes++;
         end
         checks++; if (ready_out !== (k >= 7)) $display("FAIL basic ready k=%0d: got %b required %b", k, ready_out, (k >= 7)); else passes++;
         checks++; if (busy_out !== (k < 7)) $display("FAIL basic busy k=%0d: got %b required %b", k, busy_out, (k < 7)); else passes++;
         if (k < 7) tick();
      end
      checks++; if (num_points_out !== 6'd0) $display("FAIL basic pre-swap count: got %0d required 0", num_points_out); else passes++;
      swap();
      checks++; if (ready_out !== 1'b0) $display("FAIL basic ready after swap: got %b required 0", ready_out); else passes++;
      checks++; if (num_points_out !== 6'd4) $display("FAIL basic count: got %0d required 4", num_points_out); else passes++;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (xs[i] !== mx(10'(10'h010 + i)) || ys[i] !== my(10'(10'h010 + i)))
            $display("FAIL basic vertex %0d: got (%0d,%0d) required (%0d,%0d)", i, xs[i], ys[i], $signed(mx(10'(10'h010 + i))), $signed(my(10'(10'h010 + i))));
         else passes++;
      end
   endtask

   task automatic test_error;
      logic signed [W-1:0] x0;
      x0 = xs[0];
      start(10'h020, 6'd33);
      checks++; if (error_out !== 1'b1) $display("FAIL error pulse: got %b required 1", error_out); else passes++;
      checks++; if (busy_out !== 1'b0) $display("FAIL error busy: got %b required 0", busy_out); else passes++;
      tick();
      checks++; if (error_out !== 1'b0) $display("FAIL error width: got %b required 0", error_out); else passes++;
      checks++; if (busy_out !== 1'b0 || ready_out !== 1'b0) $display("FAIL error state: busy=%b ready=%b required 0 0", busy_out, ready_out); else passes++;
      checks++; if (num_points_out !== 6'd4 || xs[0] !== x0) $display("FAIL error active: count=%0d x0=%0d required 4 %0d", num_points_out, xs[0], x0); else passes++;
   endtask

   task automatic test_bbox;
      logic signed [W-1:0] e_minx, e_maxx, e_miny, e_maxy;
`ifdef POLYGON_LOADER_BBOX_EN
      e_minx = -5; e_maxx = 7; e_miny = -2; e_maxy = 9;
`else
      e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
`endif
      start(10'h100, 6'd3);
      wait_ready("bbox");
      swap();
      checks++; if (num_points_out !== 6'd3) $display("FAIL bbox count: got %0d required 3", num_points_out); else passes++;
      checks++; if (xs[0] !== -5 || ys[1] !== -2 || ys[2] !== 9) $display("FAIL bbox vertices: x0=%0d y1=%0d y2=%0d required -5 -2 9", xs[0], ys[1], ys[2]); else passes++;
      checks++; if (bminx !== e_minx || bmaxx !== e_maxx) $display("FAIL bbox x: got [%0d,%0d] required [%0d,%0d]", bminx, bmaxx, e_minx, e_maxx); else passes++;
      checks++; if (bminy !== e_miny || bmaxy !== e_maxy) $display("FAIL bbox y: got [%0d,%0d] required [%0d,%0d]", bminy, bmaxy, e_miny, e_maxy); else passes++;
   endtask

   task automatic test_wrap;
      logic [AB-1:0] exp_a [4];
      exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
      start(10'h3FE, 6'd4);
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_addr_out !== exp_a[i]) $display("FAIL wrap addr %0d: got %h required %h", i, mem_addr_out, exp_a[i]); else passes++;
         tick();
      end
      wait_ready("wrap");
      swap();
      checks++; if (xs[2] !== mx(10'h000) || ys[3] !== my(10'h001)) $display("FAIL wrap data: x2=%0d y3=%0d required %0d %0d", xs[2], ys[3], $signed(mx(10'h000)), $signed(my(10'h001))); else passes++;
   endtask

   task automatic test_swap_hold_and_ignored_start;
      int n;
      swap_in = 1'b1;
      start(10'h200, 6'd8);
      n = 0;
      while (ready_out !== 1'b1 && n < 40) begin
         checks++; if (num_points_out !== 6'd4 || xs[0] !== mx(10'h3FE)) $display("FAIL hold cycle %0d: count=%0d required 4 and unchanged x0", n, num_points_out); else passes++;
         if (n == 2) begin
            base_addr_in = 10'h300; count_in = 6'd2; start_in = 1'b1;
         end
         tick();
         start_in = 1'b0;
         if (n == 2) begin
            checks++; if (error_out !== 1'b0) $display("FAIL ignored start error: got %b required 0", error_out); else passes++;
         end
         n++;
      end
      checks++; if (ready_out !== 1'b1) $display("FAIL hold ready: got %b required 1 within 40 cycles", ready_out); else passes++;
      tick();
      swap_in = 1'b0;
      checks++; if (num_points_out !== 6'd8 || ready_out !== 1'b0) $display("FAIL hold commit: count=%0d ready=%b required 8 0", num_points_out, ready_out); else passes++;
      for (int i = 0; i < 8; i++) begin
         checks++; if (xs[i] !== mx(10'(10'h200 + i))) $display("FAIL hold vertex %0d: got %0d required %0d", i, xs[i], $signed(mx(10'(10'h200 + i)))); else passes++;
      end
   endtask

   task automatic test_back_to_back;
      start(10'h040, 6'd5);
      wait_ready("b2b first");
      swap_in = 1'b1;
      start(10'h050, 6'd3);
      swap_in = 1'b0;
      checks++; if (num_points_out !== 6'd5) $display("FAIL b2b commit count: got %0d required 5", num_points_out); else passes++;
      checks++; if (xs[4] !== mx(10'h044) || ys[0] !== my(10'h040)) $display("FAIL b2b commit data: x4=%0d y0=%0d", xs[4], ys[0]); else passes++;
      checks++; if (busy_out !== 1'b1 || ready_out !== 1'b0 || mem_addr_out !== 10'h050) $display("FAIL b2b restart: busy=%b ready=%b addr=%h required 1 0 050", busy_out, ready_out, mem_addr_out); else passes++;
      wait_ready("b2b second");
      swap();
      checks++; if (num_points_out !== 6'd3 || xs[2] !== mx(10'h052)) $display("FAIL b2b second: count=%0d x2=%0d required 3 %0d", num_points_out, xs[2], $signed(mx(10'h052))); else passes++;
      checks++; if (xs[3] !== mx(10'h043)) $display("FAIL b2b stale entry: x3=%0d required %0d", xs[3], $signed(mx(10'h043))); else passes++;
   endtask

   task automatic test_zero_count;
      start(10'h123, 6'd0);
      checks++; if (busy_out !== 1'b0 || ready_out !== 1'b0) $display("FAIL zero edge t: busy=%b ready=%b required 0 0", busy_out, ready_out); else passes++;
      tick();
      checks++; if (busy_out !== 1'b0 || ready_out !== 1'b1) $display("FAIL zero edge t+1: busy=%b ready=%b required 0 1", busy_out, ready_out); else passes++;
      swap();
      checks++; if (num_points_out !== 6'd0) $display("FAIL zero count: got %0d required 0", num_points_out); else passes++;
      checks++; if ({bminx, bmaxx, bminy, bmaxy} !== '0) $display("FAIL zero bbox: got %0d %0d %0d %0d required 0", bminx, bmaxx, bminy, bmaxy); else passes++;
   endtask

   task automatic test_reset_mid_fetch;
      start(10'h080, 6'd8);
      tick(); tick();
      checks++; if (busy_out !== 1'b1) $display("FAIL midreset pre busy: got %b required 1", busy_out); else passes++;
      #2 rst_in = 1'b1;
      #1;
      checks++; if (num_points_out !== 6'd0 || busy_out !== 1'b0 || mem_addr_out !== 10'd0) $display("FAIL midreset async: count=%0d busy=%b addr=%h required 0 0 000", num_points_out, busy_out, mem_addr_out); else passes++;
      checks++; if (xs[0] !== 0 || ys[2] !== 0) $display("FAIL midreset arrays: x0=%0d y2=%0d required 0", xs[0], ys[2]); else passes++;
      tick();
      rst_in = 1'b0;
      tick();
      start(10'h090, 6'd2);
      wait_ready("midreset reload");
      swap();
      checks++; if (num_points_out !== 6'd2 || xs[1] !== mx(10'h091) || ys[0] !== my(10'h090)) $display("FAIL midreset reload: count=%0d x1=%0d y0=%0d", num_points_out, xs[1], ys[0]); else passes++;
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) mem[a] = {32'(a * 5 - 2000), 32'(700 - a * 3)};
      mem[10'h100] = {32'(-5), 32'(3)};
      mem[10'h101] = {32'(7), 32'(-2)};
      mem[10'h102] = {32'(0), 32'(9)};
      test_reset();
      test_basic_load();
      test_error();
      test_bbox();
      test_wrap();
      test_swap_hold_and_ignored_start();
      test_back_to_back();
      test_zero_count();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
